// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port ids and
// the default instruction-port starvation limit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_perf.sv
// Wrapping 32-bit grant and conflict counters for the memory arbiter.
// Only instantiated when ARB_PERF_CNT_EN is defined.
module mem_arb_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        arb_fire,
  input  logic        grant_i,
  input  logic        conflict,
  output logic [31:0] cnt_i_grant,
  output logic [31:0] cnt_d_grant,
  output logic [31:0] cnt_conflict
);

  logic [31:0] cnt_i_grant_q, cnt_i_grant_d;
  logic [31:0] cnt_d_grant_q, cnt_d_grant_d;
  logic [31:0] cnt_conflict_q, cnt_conflict_d;

  always_comb begin
    cnt_i_grant_d  = cnt_i_grant_q;
    cnt_d_grant_d  = cnt_d_grant_q;
    cnt_conflict_d = cnt_conflict_q;
    if (arb_fire) begin
      if (grant_i) cnt_i_grant_d = cnt_i_grant_q + 32'd1;
      else         cnt_d_grant_d = cnt_d_grant_q + 32'd1;
      if (conflict) cnt_conflict_d = cnt_conflict_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_i_grant_q  <= '0;
      cnt_d_grant_q  <= '0;
      cnt_conflict_q <= '0;
    end else begin
      cnt_i_grant_q  <= cnt_i_grant_d;
      cnt_d_grant_q  <= cnt_d_grant_d;
      cnt_conflict_q <= cnt_conflict_d;
    end
  end

  assign cnt_i_grant  = cnt_i_grant_q;
  assign cnt_d_grant  = cnt_d_grant_q;
  assign cnt_conflict = cnt_conflict_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Instruction/data port arbiter in front of one single-port memory; data wins
// unless the instruction port has lost STARVE_LIMIT times. ARB_PERF_CNT_EN adds counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] cnt_i_grant,
  output logic [31:0] cnt_d_grant,
  output logic [31:0] cnt_conflict
`endif
);

  localparam int WAIT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v >= WAIT_MAX) ? WAIT_MAX : v + 1'b1;
  endfunction

  state_e      state_q, state_d;
  port_e       win_q, win_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [WAIT_W-1:0] i_wait_q, i_wait_d;
  logic [31:0] rdata_q, rdata_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic any_req;
  logic i_wins;
  logic arb_fire;

  assign any_req  = i_req | d_req;
  assign i_wins   = i_req & (~d_req | (i_wait_q == WAIT_MAX));
  assign arb_fire = (state_q == IDLE) & any_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      win_q     <= PORT_I;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_wait_q  <= '0;
      rdata_q   <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_wait_q  <= i_wait_d;
      rdata_q   <= rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Acks and rdata are registered on the RESP->IDLE edge, so a reset in RESP swallows the ack.
  always_comb begin
    win_d     = win_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_wait_d  = i_wait_q;
    rdata_d   = rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (arb_fire) begin
      win_d   = i_wins ? PORT_I : PORT_D;
      addr_d  = i_wins ? i_addr : d_addr;
      we_d    = ~i_wins & d_we;
      wdata_d = i_wins ? 32'd0 : d_wdata;
      if (i_wins)     i_wait_d = '0;
      else if (i_req) i_wait_d = sat_inc(i_wait_q);
    end
    if (state_q == ACCESS) rdata_d = we_q ? 32'd0 : mem_rdata;
    if (state_q == RESP) begin
      if (win_q == PORT_I) begin
        i_ack_d   = 1'b1;
        i_rdata_d = rdata_q;
      end else begin
        d_ack_d   = 1'b1;
        d_rdata_d = rdata_q;
      end
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ACCESS) begin
      mem_read  = ~we_q;
      mem_write = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
  end

  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

`ifdef ARB_PERF_CNT_EN
  logic conflict;
  assign conflict = arb_fire & i_req & d_req;

  mem_arb_perf u_perf (
    .clk          (clk),
    .reset        (reset),
    .arb_fire     (arb_fire),
    .grant_i      (i_wins),
    .conflict     (conflict),
    .cnt_i_grant  (cnt_i_grant),
    .cnt_d_grant  (cnt_d_grant),
    .cnt_conflict (cnt_conflict)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] cnt_i_grant;
  logic [31:0] cnt_d_grant;
  logic [31:0] cnt_conflict;
`endif

  logic [31:0] mem [0:63];
  logic        bk_we = 1'b0;
  logic [5:0]  bk_addr = '0;
  logic [31:0] bk_data = '0;

  int n_chk = 0;
  int n_pass = 0;
  int mem_viol = 0;
  logic prev_active = 1'b0;
  logic active;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
`ifdef ARB_PERF_CNT_EN
    ,
    .cnt_i_grant  (cnt_i_grant),
    .cnt_d_grant  (cnt_d_grant),
    .cnt_conflict (cnt_conflict)
`endif
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_write)  mem[mem_addr[7:2]] <= mem_wdata;
    else if (bk_we) mem[bk_addr] <= bk_data;
  end

  // Bus-legality monitor: one-hot strobe, single-cycle ACCESS, quiet bus otherwise.
  assign active = mem_read | mem_write;
  always @(negedge clk) begin
    if ((mem_read && mem_write) || (active && prev_active) || (active && !busy) ||
        (!active && (mem_addr != 32'd0 || mem_wdata != 32'd0)))
      mem_viol <= mem_viol + 1;
    prev_active <= active;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    logic seen;
    logic [31:0] base_i, base_d, base_c;
    base_i = '0; base_d = '0; base_c = '0;

    bk_we = 1'b1; bk_addr = 6'd1; bk_data = 32'h2001_0005;
    tick();
    bk_we = 1'b0;

    reset = 1'b1;
    tick();
    tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_i_ack", {31'b0, i_ack}, 32'd0);
    chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_strb", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;
    tick();

    // Short pulse between edges is never sampled.
    i_req = 1'b1;
    #3 i_req = 1'b0;
    tick();
    chk("glitch_busy", {31'b0, busy}, 32'd0);

    // Single instruction read.
    i_req = 1'b1; i_addr = 32'h4;
    tick();
    chk("ird_busy", {31'b0, busy}, 32'd1);
    chk("ird_strb", {30'b0, mem_read, mem_write}, 32'd2);
    i_addr = 32'h8;
    #1;
    chk("ird_addr_held", mem_addr, 32'h4);
    tick();
    chk("ird_ack_early", {31'b0, i_ack}, 32'd0);
    chk("ird_resp_quiet", {30'b0, mem_read, mem_write}, 32'd0);
    tick();
    chk("ird_ack", {31'b0, i_ack}, 32'd1);
    chk("ird_rdata", i_rdata, 32'h2001_0005);
    chk("ird_d_ack", {31'b0, d_ack}, 32'd0);
    i_req = 1'b0;
    tick();
    chk("ird_ack_pulse", {31'b0, i_ack}, 32'd0);
    chk("ird_rdata_hold", i_rdata, 32'h2001_0005);
    chk("ird_idle", {31'b0, busy}, 32'd0);

    // Data write then instruction read-back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("dwr_strb", {30'b0, mem_read, mem_write}, 32'd1);
    chk("dwr_addr", mem_addr, 32'h10);
    chk("dwr_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("dwr_one_cycle", {31'b0, mem_write}, 32'd0);
    chk("dwr_ack_early", {31'b0, d_ack}, 32'd0);
    tick();
    chk("dwr_ack", {31'b0, d_ack}, 32'd1);
    chk("dwr_rdata", d_rdata, 32'd0);
    chk("dwr_i_ack", {31'b0, i_ack}, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    i_req = 1'b1; i_addr = 32'h10;
    tick();
    tick();
    tick();
    chk("rb_ack", {31'b0, i_ack}, 32'd1);
    chk("rb_rdata", i_rdata, 32'hDEAD_BEEF);
    chk("rb_d_ack", {31'b0, d_ack}, 32'd0);
    i_req = 1'b0;
    tick();

    // Contention with both requests held: D,D,D,D,I repeating.
`ifdef ARB_PERF_CNT_EN
    base_i = cnt_i_grant; base_d = cnt_d_grant; base_c = cnt_conflict;
`endif
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
    for (int g = 0; g < 10; g++) begin
      cyc = 0;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
        tick();
        cyc++;
        if (i_ack || d_ack) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        chk("grant_timeout", 32'd0, 32'd1);
        break;
      end
      chk("grant_order", {31'b0, i_ack}, (g == 4 || g == 9) ? 32'd1 : 32'd0);
      chk("grant_one_ack", {31'b0, i_ack & d_ack}, 32'd0);
      chk("grant_spacing", cyc, 32'd3);
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("cont_d_rdata", d_rdata, 32'h2001_0005);
    chk("cont_i_rdata", i_rdata, 32'hDEAD_BEEF);
`ifdef ARB_PERF_CNT_EN
    chk("perf_conflict", cnt_conflict - base_c, 32'd10);
    chk("perf_d_grant", cnt_d_grant - base_d, 32'd8);
    chk("perf_i_grant", cnt_i_grant - base_i, 32'd2);
`endif
    tick();

    // Reset during RESP aborts without an ack.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
    tick();
    tick();
    chk("abort_in_resp", {31'b0, busy}, 32'd1);
    reset = 1'b1; d_req = 1'b0;
    tick();
    chk("abort_d_ack", {31'b0, d_ack}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_d_rdata", d_rdata, 32'd0);
    reset = 1'b0;
    tick();
    chk("abort_d_ack2", {31'b0, d_ack}, 32'd0);
    d_req = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_ack", {31'b0, d_ack}, 32'd1);
    chk("post_rst_rdata", d_rdata, 32'h2001_0005);

    // Request still high after ack becomes a new transaction (here a write).
    d_we = 1'b1; d_addr = 32'h14; d_wdata = 32'h1234_5678;
    tick();
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    chk("b2b_ack_low", {31'b0, d_ack}, 32'd0);
    tick();
    tick();
    chk("b2b_ack", {31'b0, d_ack}, 32'd1);
    chk("b2b_wr_rdata", d_rdata, 32'd0);
    chk("b2b_mem", mem[5], 32'h1234_5678);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    tick();

    chk("mem_bus_rules", mem_viol, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
